// File: rtl/dac_spi_tx_if.sv
// Sample handshake between the sine ROM (master) and the DAC serialiser (slave).
// sample_ready doubles as the generator's address-advance enable.
interface dac_spi_tx_if #(
  parameter int D_WIDTH = 8
);
  logic               sample_valid;
  logic [D_WIDTH-1:0] sample_data;
  logic               sample_ready;

  modport master (
    output sample_valid,
    output sample_data,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    output sample_ready
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Frames each accepted ROM sample as {CFG_BITS, sample, zero pad} and shifts it
// MSB-first to an SPI DAC (mode 0: sclk idles low, data stable on the rising edge).
module dac_spi_tx #(
  parameter int          D_WIDTH    = 8,
  parameter int          CLK_DIV    = 2,
  parameter int          GAP_CYCLES = 2,
  parameter logic [3:0]  CFG_BITS   = 4'b0011
) (
  input  logic         clk,
  input  logic         rst,
  dac_spi_tx_if.slave  smp,
  output logic         sclk,
  output logic         cs_n,
  output logic         mosi,
  output logic         busy,
  output logic [15:0]  frame_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int PAD   = 12 - D_WIDTH;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state;
  logic [15:0]        shift_reg;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         fall_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [11:0]        field;
  logic [15:0]        frame;

  // Left-justify the sample in the 12-bit data field; low bits pad with zeros.
  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_field
      if (gi >= PAD) begin : g_data
        assign field[gi] = smp.sample_data[gi - PAD];
      end else begin : g_pad
        assign field[gi] = 1'b0;
      end
    end
  endgenerate

  assign frame            = {CFG_BITS, field};
  assign smp.sample_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      div_cnt     <= '0;
      fall_cnt    <= '0;
      gap_cnt     <= '0;
      sclk        <= 1'b0;
      cs_n        <= 1'b1;
      mosi        <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (smp.sample_valid) begin
            shift_reg <= frame;
            mosi      <= frame[15];
            cs_n      <= 1'b0;
            sclk      <= 1'b0;
            div_cnt   <= '0;
            fall_cnt  <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            // Data only moves on falling edges so mosi is settled at every rise.
            if (sclk) begin
              if (fall_cnt == 4'd15) begin
                cs_n        <= 1'b1;
                mosi        <= 1'b0;
                shift_reg   <= '0;
                frame_count <= frame_count + 16'd1;
                gap_cnt     <= '0;
                state       <= GAP;
              end else begin
                shift_reg <= {shift_reg[14:0], 1'b0};
                mosi      <= shift_reg[14];
                fall_cnt  <= fall_cnt + 4'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a default instance and a fast (CLK_DIV=1, GAP=1) instance,
// with a serial monitor that reassembles frames and checks them against a scoreboard queue.
`timescale 1ns/1ps
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic sclk0, cs0, mosi0, busy0;
  logic sclk1, cs1, mosi1, busy1;
  logic [15:0] fc0, fc1;

  dac_spi_tx_if #(.D_WIDTH(8)) if0 ();
  dac_spi_tx_if #(.D_WIDTH(8)) if1 ();

  dac_spi_tx #(.D_WIDTH(8), .CLK_DIV(2), .GAP_CYCLES(2), .CFG_BITS(4'b0011)) dut0 (
    .clk(clk), .rst(rst0), .smp(if0),
    .sclk(sclk0), .cs_n(cs0), .mosi(mosi0), .busy(busy0), .frame_count(fc0)
  );

  dac_spi_tx #(.D_WIDTH(8), .CLK_DIV(1), .GAP_CYCLES(1), .CFG_BITS(4'b0011)) dut1 (
    .clk(clk), .rst(rst1), .smp(if1),
    .sclk(sclk1), .cs_n(cs1), .mosi(mosi1), .busy(busy1), .frame_count(fc1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];
  int          fall0 [$];
  int          fall1 [$];

  int          rises     [2];
  int          low_cyc   [2];
  int          last_rise [2];
  logic [15:0] word      [2];
  logic        prev_sc   [2];
  logic        prev_cs   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [7:0] d);
    return {4'b0011, d, 4'b0000};
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic get_ready(input int k);
    return (k == 0) ? if0.sample_ready : if1.sample_ready;
  endfunction

  function automatic logic get_busy(input int k);
    return (k == 0) ? busy0 : busy1;
  endfunction

  task automatic drive(input int k, input logic v, input logic [7:0] d);
    if (k == 0) begin if0.sample_valid = v; if0.sample_data = d; end
    else        begin if1.sample_valid = v; if1.sample_data = d; end
  endtask

  task automatic push_exp(input int k, input logic [15:0] f);
    if (k == 0) exp0.push_back(f); else exp1.push_back(f);
  endtask

  // Serial monitor: reassembles frames from mosi at sclk rises while cs_n is low.
  task automatic mon(input int k, input logic r, input logic sc, input logic cs,
                     input logic mo, input int cd);
    logic [15:0] e;
    if (!r) begin
      rises[k] = 0; low_cyc[k] = 0; prev_sc[k] = 1'b0; prev_cs[k] = 1'b1;
      return;
    end
    if (prev_cs[k] && !cs) begin
      rises[k] = 0; low_cyc[k] = 0; word[k] = '0;
      if (k == 0) fall0.push_back(cyc); else fall1.push_back(cyc);
    end
    if (!cs) begin
      low_cyc[k]++;
      if (sc && !prev_sc[k]) begin
        if (rises[k] > 0)
          check($sformatf("sclk_period_%0d", k), 32'(cyc - last_rise[k]), 32'(2 * cd));
        last_rise[k] = cyc;
        rises[k]++;
        word[k] = {word[k][14:0], mo};
      end
    end
    if (!prev_cs[k] && cs) begin
      check($sformatf("sclk_low_at_cs_rise_%0d", k), 32'(sc), 32'(0));
      check($sformatf("cs_low_cycles_%0d", k), 32'(low_cyc[k]), 32'(32 * cd));
      check($sformatf("bit_count_%0d", k), 32'(rises[k]), 32'(16));
      check($sformatf("sb_nonempty_%0d", k), 32'(qsize(k) != 0), 32'(1));
      if (qsize(k) != 0) begin
        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        check($sformatf("frame_%0d", k), 32'(word[k]), 32'(e));
      end
    end
    prev_sc[k] = sc;
    prev_cs[k] = cs;
  endtask

  always @(negedge clk) begin
    mon(0, rst0, sclk0, cs0, mosi0, 2);
    mon(1, rst1, sclk1, cs1, mosi1, 1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] d);
    int i = 0;
    while (!get_ready(k) && i < 200) begin tick(); i++; end
    check($sformatf("ready_before_send_%0d", k), 32'(get_ready(k)), 32'(1));
    drive(k, 1'b1, d);
    push_exp(k, mk(d));
    tick();
    drive(k, 1'b0, 8'h00);
    check($sformatf("busy_after_accept_%0d", k), 32'({get_busy(k), get_ready(k)}), 32'(2'b10));
  endtask

  task automatic wait_idle(input int k, input int budget);
    int i = 0;
    while ((qsize(k) != 0 || !get_ready(k)) && i < budget) begin tick(); i++; end
    check($sformatf("wait_timeout_%0d", k), 32'({qsize(k) != 0, get_ready(k)}), 32'(2'b01));
  endtask

  // Hold valid high and let the DUT take two samples; data switches right after each accept.
  task automatic accept_two(input int k, input logic [7:0] d0, input logic [7:0] d1,
                            input int spacing);
    int acc_cyc [2];
    int n = 0;
    logic [7:0] cur;
    cur = d0;
    drive(k, 1'b1, cur);
    for (int i = 0; i < 400 && n < 2; i++) begin
      logic acc_now;
      acc_now = get_ready(k);
      if (acc_now) begin
        acc_cyc[n] = cyc;
        push_exp(k, mk(cur));
        n++;
      end
      tick();
      if (acc_now) begin
        cur = (n == 1) ? d1 : 8'h12;
        drive(k, (n < 2), cur);
      end
    end
    check($sformatf("accept_count_%0d", k), 32'(n), 32'(2));
    if (n == 2)
      check($sformatf("accept_spacing_%0d", k), 32'(acc_cyc[1] - acc_cyc[0]), 32'(spacing));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int f_a, f_b;
    rst0 = 1'b0; rst1 = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    tick(); tick();
    check("in_reset_0", 32'({cs0, sclk0, mosi0, if0.sample_ready, busy0, fc0}), 32'({5'b10010, 16'h0}));

    // 1. Idle after reset release.
    rst0 = 1'b1; rst1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_0", 32'({cs0, sclk0, mosi0, if0.sample_ready, busy0, fc0}), 32'({5'b10010, 16'h0}));
    end
    check("idle_1", 32'({cs1, sclk1, mosi1, if1.sample_ready, busy1, fc1}), 32'({5'b10010, 16'h0}));

    // 2. Single sample 0xA5.
    send(0, 8'hA5);
    wait_idle(0, 300);
    check("count_after_a5", 32'(fc0), 32'(1));

    // 3. Valid held high: 0x00 then 0xFF, 67 cycles apart.
    fall0.delete();
    accept_two(0, 8'h00, 8'hFF, 67);
    wait_idle(0, 400);
    check("count_after_b2b", 32'(fc0), 32'(3));
    check("cs_fall_events_0", 32'(fall0.size()), 32'(2));
    if (fall0.size() == 2) begin
      f_a = fall0.pop_front(); f_b = fall0.pop_front();
      check("cs_fall_spacing_0", 32'(f_b - f_a), 32'(67));
    end

    // 4. Fast instance: sample 0x80 twice, 34 cycles apart.
    fall1.delete();
    accept_two(1, 8'h80, 8'h80, 34);
    wait_idle(1, 200);
    check("count_fast", 32'(fc1), 32'(2));

    // 5. Asynchronous reset at the 7th sclk rise.
    send(0, 8'h3C);
    i = 0;
    while (rises[0] < 7 && i < 100) begin tick(); i++; end
    check("reached_7th_rise", 32'(rises[0]), 32'(7));
    #2 rst0 = 1'b0;
    #1 check("async_reset_0", 32'({cs0, sclk0, mosi0, if0.sample_ready, busy0, fc0}), 32'({5'b10010, 16'h0}));
    exp0.delete();
    tick();
    rst0 = 1'b1;
    tick();
    send(0, 8'hC3);
    wait_idle(0, 300);
    check("count_after_reset", 32'(fc0), 32'(1));

    // 6. Counter wrap.
    @(negedge clk);
    force dut0.frame_count = 16'hFFFF;
    #1 release dut0.frame_count;
    tick();
    check("count_preset", 32'(fc0), 32'(16'hFFFF));
    send(0, 8'h5A);
    wait_idle(0, 300);
    check("count_wrap", 32'(fc0), 32'(0));
    check("fast_unaffected", 32'(fc1), 32'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
